// File: rtl/flow_pop_scheduler.sv
// Per-flow push router and round-robin pop scheduler for the flow rank store.
// Define STRICT_PRIO_EN for fixed priority (flow 0 highest) instead of round-robin.
module flow_pop_scheduler #(
  parameter int SIZE   = 50,
  parameter int FLOWS  = 10,
  parameter int FLOW_W = $clog2(FLOWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_push,
  input  logic [31:0]       in_rank,
  input  logic [31:0]       in_value,
  input  logic [FLOW_W-1:0] in_flow,
  output logic              in_ready,
  input  logic              deq_req,
  output logic              out_valid,
  output logic [31:0]       out_value,
  output logic [31:0]       out_rank,
  output logic [FLOW_W-1:0] out_flow,
  output logic              out_empty,
  output logic [FLOWS-1:0]  flow_empty,
  output logic              st_push,
  output logic [31:0]       st_push_rank,
  output logic [31:0]       st_push_value,
  output logic [FLOWS-1:0]  st_push_flow,
  output logic              st_pop,
  output logic [FLOWS-1:0]  st_pop_flow,
  input  logic [31:0]       st_pop_value,
  input  logic [31:0]       st_pop_rank,
  input  logic              st_pop_valid
);

  localparam int CNT_W = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt [FLOWS];
  logic [FLOWS-1:0]  nonempty;
  logic [FLOWS-1:0]  sel_oh;
  logic [FLOWS-1:0]  pop_oh;
  logic [FLOW_W-1:0] grant;
  logic [FLOW_W-1:0] sel;
  logic [FLOW_W-1:0] rr_ptr;
  logic              sel_ok;
  logic              issue_go;
  logic              empty_go;
  logic              capture;

  always_comb begin
    for (int f = 0; f < FLOWS; f++) begin
      nonempty[f] = (cnt[f] != '0);
    end
  end

  assign flow_empty = ~nonempty;

  // Walk the flows explicitly so an out-of-range in_flow never indexes cnt.
  always_comb begin
    in_ready = 1'b0;
    for (int f = 0; f < FLOWS; f++) begin
      if (in_flow == FLOW_W'(f) && cnt[f] < CNT_W'(SIZE)) begin
        in_ready = 1'b1;
      end
    end
  end

  assign st_push       = in_push & in_ready;
  assign st_push_rank  = in_rank;
  assign st_push_value = in_value;

  always_comb begin
    for (int f = 0; f < FLOWS; f++) begin
      st_push_flow[f] = st_push && (in_flow == FLOW_W'(f));
    end
  end

`ifdef STRICT_PRIO_EN
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    for (int f = FLOWS - 1; f >= 0; f--) begin
      if (nonempty[f]) begin
        sel    = FLOW_W'(f);
        sel_ok = 1'b1;
      end
    end
  end
`else
  // Descending scan so the nearest flow after rr_ptr is written last.
  always_comb begin
    int idx;
    idx    = 0;
    sel    = '0;
    sel_ok = 1'b0;
    for (int i = FLOWS; i >= 1; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= FLOWS) idx = idx - FLOWS;
      if (nonempty[idx]) begin
        sel    = FLOW_W'(idx);
        sel_ok = 1'b1;
      end
    end
  end
`endif

  assign sel_oh = {{(FLOWS-1){1'b0}}, 1'b1} << sel;

  always_comb begin
    pop_oh = '0;
    if (state == ISSUE) begin
      pop_oh = {{(FLOWS-1){1'b0}}, 1'b1} << grant;
    end
  end

  always_comb begin
    state_d  = state;
    issue_go = 1'b0;
    empty_go = 1'b0;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (deq_req) begin
          if (sel_ok) begin
            issue_go = 1'b1;
            state_d  = ISSUE;
          end else begin
            empty_go = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (st_pop_valid) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= FLOW_W'(FLOWS - 1);
      st_pop      <= 1'b0;
      st_pop_flow <= '0;
      out_valid   <= 1'b0;
      out_empty   <= 1'b0;
      out_value   <= '0;
      out_rank    <= '0;
      out_flow    <= '0;
    end else begin
      state       <= state_d;
      st_pop      <= issue_go;
      st_pop_flow <= issue_go ? sel_oh : '0;
      out_valid   <= capture;
      out_empty   <= empty_go;
      if (issue_go) begin
        grant <= sel;
`ifndef STRICT_PRIO_EN
        rr_ptr <= sel;
`endif
      end
      if (capture) begin
        out_value <= st_pop_value;
        out_rank  <= st_pop_rank;
        out_flow  <= grant;
      end
    end
  end

  // A push and a pop on the same flow cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FLOWS; f++) begin
        cnt[f] <= '0;
      end
    end else begin
      for (int f = 0; f < FLOWS; f++) begin
        if (st_push_flow[f] && !pop_oh[f]) begin
          cnt[f] <= cnt[f] + CNT_W'(1);
        end else if (!st_push_flow[f] && pop_oh[f]) begin
          cnt[f] <= cnt[f] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_flow_pop_scheduler.sv
// Directed plus random bench for flow_pop_scheduler with a FIFO store model.
// Reference keeps per-flow queues and a round-robin pointer as plain ints.
module tb_flow_pop_scheduler;

  localparam int SIZE   = 50;
  localparam int FLOWS  = 10;
  localparam int FLOW_W = $clog2(FLOWS);

  logic              clk;
  logic              rst;
  logic              in_push;
  logic [31:0]       in_rank;
  logic [31:0]       in_value;
  logic [FLOW_W-1:0] in_flow;
  logic              in_ready;
  logic              deq_req;
  logic              out_valid;
  logic [31:0]       out_value;
  logic [31:0]       out_rank;
  logic [FLOW_W-1:0] out_flow;
  logic              out_empty;
  logic [FLOWS-1:0]  flow_empty;
  logic              st_push;
  logic [31:0]       st_push_rank;
  logic [31:0]       st_push_value;
  logic [FLOWS-1:0]  st_push_flow;
  logic              st_pop;
  logic [FLOWS-1:0]  st_pop_flow;
  logic [31:0]       st_pop_value;
  logic [31:0]       st_pop_rank;
  logic              st_pop_valid;

  int ntests = 0;
  int nfail  = 0;

  int          mcnt [FLOWS];
  logic [63:0] mq   [FLOWS][$];
  int          rr;
  logic [63:0] sq   [FLOWS][$];
  int          last_flow;

  flow_pop_scheduler #(.SIZE(SIZE), .FLOWS(FLOWS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_push      (in_push),
    .in_rank      (in_rank),
    .in_value     (in_value),
    .in_flow      (in_flow),
    .in_ready     (in_ready),
    .deq_req      (deq_req),
    .out_valid    (out_valid),
    .out_value    (out_value),
    .out_rank     (out_rank),
    .out_flow     (out_flow),
    .out_empty    (out_empty),
    .flow_empty   (flow_empty),
    .st_push      (st_push),
    .st_push_rank (st_push_rank),
    .st_push_value(st_push_value),
    .st_push_flow (st_push_flow),
    .st_pop       (st_pop),
    .st_pop_flow  (st_pop_flow),
    .st_pop_value (st_pop_value),
    .st_pop_rank  (st_pop_rank),
    .st_pop_valid (st_pop_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store stand-in: FIFO per flow, answers a pop one cycle later.
  always @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < FLOWS; f++) sq[f].delete();
      st_pop_valid <= 1'b0;
      st_pop_value <= '0;
      st_pop_rank  <= '0;
    end else begin
      st_pop_valid <= 1'b0;
      if (st_pop) begin
        for (int f = 0; f < FLOWS; f++) begin
          if (st_pop_flow[f] && sq[f].size() > 0) begin
            {st_pop_rank, st_pop_value} <= sq[f].pop_front();
            st_pop_valid <= 1'b1;
          end
        end
      end
      if (st_push) begin
        for (int f = 0; f < FLOWS; f++) begin
          if (st_push_flow[f]) sq[f].push_back({st_push_rank, st_push_value});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLOWS-1:0] exp_empty();
    logic [FLOWS-1:0] v;
    for (int f = 0; f < FLOWS; f++) v[f] = (mcnt[f] == 0);
    return v;
  endfunction

  function automatic logic [FLOWS-1:0] onehot(input int f);
    logic [FLOWS-1:0] one;
    one = 1;
    return one << f;
  endfunction

  function automatic int pick();
`ifdef STRICT_PRIO_EN
    for (int i = 0; i < FLOWS; i++) if (mcnt[i] > 0) return i;
`else
    int f;
    for (int i = 1; i <= FLOWS; i++) begin
      f = (rr + i) % FLOWS;
      if (mcnt[f] > 0) return f;
    end
`endif
    return -1;
  endfunction

  function automatic bit can_push(input int f);
    if (f >= FLOWS) return 1'b0;
    return mcnt[f] < SIZE;
  endfunction

  task automatic model_clear();
    for (int f = 0; f < FLOWS; f++) begin
      mcnt[f] = 0;
      mq[f].delete();
    end
    rr = FLOWS - 1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_push  = 1'b0;
    deq_req  = 1'b0;
    in_rank  = '0;
    in_value = '0;
    in_flow  = '0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    check("rst_flow_empty", flow_empty, {FLOWS{1'b1}});
    check("rst_st_pop", st_pop, 0);
    check("rst_st_pop_flow", st_pop_flow, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_empty", out_empty, 0);
    check("rst_out_data", {out_rank, out_value}, 0);
    check("rst_out_flow", out_flow, 0);
  endtask

  task automatic push(input int f, input logic [31:0] r, input logic [31:0] v);
    bit ok;
    ok       = can_push(f);
    in_push  = 1'b1;
    in_flow  = FLOW_W'(f);
    in_rank  = r;
    in_value = v;
    #1;
    check("in_ready", in_ready, ok);
    check("st_push", st_push, ok);
    check("st_push_flow", st_push_flow, ok ? onehot(f) : '0);
    check("st_push_data", {st_push_rank, st_push_value}, {r, v});
    tick();
    in_push = 1'b0;
    if (ok) begin
      mcnt[f]++;
      mq[f].push_back({r, v});
    end
    check("push_flow_empty", flow_empty, exp_empty());
  endtask

  task automatic deq(input bit pa, input int pf, input logic [31:0] pr,
                     input logic [31:0] pv);
    int          g;
    bit          pok;
    logic [63:0] e;
    g       = pick();
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    if (g < 0) begin
      last_flow = -1;
      check("deq_out_empty", out_empty, 1);
      check("deq_empty_no_pop", st_pop, 0);
      tick();
      check("deq_out_empty_pulse", out_empty, 0);
      check("deq_empty_no_valid", out_valid, 0);
      return;
    end
`ifndef STRICT_PRIO_EN
    rr = g;
`endif
    check("issue_st_pop", st_pop, 1);
    check("issue_st_pop_flow", st_pop_flow, onehot(g));
    check("issue_no_empty", out_empty, 0);
    pok = 1'b0;
    if (pa) begin
      pok      = can_push(pf);
      in_push  = 1'b1;
      in_flow  = FLOW_W'(pf);
      in_rank  = pr;
      in_value = pv;
      #1;
      check("issue_push", st_push, pok);
    end
    e = mq[g].pop_front();
    mcnt[g]--;
    if (pok) begin
      mcnt[pf]++;
      mq[pf].push_back({pr, pv});
    end
    tick();
    in_push = 1'b0;
    check("wait_st_pop_clr", st_pop, 0);
    check("wait_st_pop_flow_clr", st_pop_flow, 0);
    check("wait_no_valid", out_valid, 0);
    tick();
    check("out_valid", out_valid, 1);
    check("out_rank", out_rank, e[63:32]);
    check("out_value", out_value, e[31:0]);
    check("out_flow", out_flow, g);
    check("deq_flow_empty", flow_empty, exp_empty());
    last_flow = int'(out_flow);
    tick();
    check("out_valid_pulse", out_valid, 0);
  endtask

  initial begin
    int order [3];
    order = '{1, 4, 7};
    rst   = 1'b1;
    do_reset();

    deq(1'b0, 0, 0, 0);
    check("idle_flow_empty", flow_empty, 10'h3FF);

    push(3, 32'd5, 32'hA);
    deq(1'b0, 0, 0, 0);
    check("single_flow", last_flow, 3);
    check("single_empty3", flow_empty[3], 1);

    do_reset();
    push(7, 32'd70, 32'h700);
    push(4, 32'd40, 32'h400);
    push(1, 32'd10, 32'h100);
    for (int i = 0; i < 3; i++) begin
      deq(1'b0, 0, 0, 0);
      check("order", last_flow, order[i]);
    end

    do_reset();
    for (int i = 0; i < SIZE; i++) push(2, i, 32'h200 + i);
    push(2, 32'd99, 32'hDEAD);
    push(12, 32'd1, 32'h1);
    deq(1'b0, 0, 0, 0);
    check("full_first_out", last_flow, 2);
    push(2, 32'd98, 32'hBEEF);
    push(2, 32'd97, 32'hCAFE);

    do_reset();
    push(0, 32'd1, 32'h11);
    deq(1'b1, 0, 32'd2, 32'h22);
    check("same_cycle_empty0", flow_empty[0], 0);
    deq(1'b0, 0, 0, 0);
    check("same_cycle_second", out_value, 32'h22);
    deq(1'b0, 0, 0, 0);

    push(5, 32'd3, 32'h55);
    deq_req = 1'b1;
    tick();
    deq_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_flow_empty", flow_empty, {FLOWS{1'b1}});
    check("midrst_st_pop", st_pop, 0);
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_valid", out_valid, 0);
    end
    deq(1'b0, 0, 0, 0);
    check("midrst_then_empty", last_flow, -1);

    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0)
        deq(1'($urandom_range(0, 1)), $urandom_range(0, 11), $urandom, $urandom);
      else
        push($urandom_range(0, 11), $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/flow_pop_scheduler.md
Name: flow_pop_scheduler

Overview:
- Sits in front of the per-flow rank store and owns all traffic to it.
- Accepts enqueues tagged with a flow index and forwards them as one-hot pushes. Tracks per-flow occupancy and rejects pushes to full flows.
- On each dequeue request, picks a non-empty flow round-robin, issues a one-cycle pop, and returns the popped value/rank with its flow index.

Parameters:
- SIZE, 50, per-flow entry capacity of the attached store (must match store SIZE)
- FLOWS, 10, number of flows (must match store FLOWS)
- FLOW_W, $clog2(FLOWS), width of the flow index

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; also drives the store's rst
- in_push  in  1  enqueue request
- in_rank  in  32  enqueue rank
- in_value  in  32  enqueue value
- in_flow  in  FLOW_W  enqueue flow index
- in_ready  out  1  combinational: in_flow < FLOWS and cnt[in_flow] < SIZE
- deq_req  in  1  dequeue request, sampled only in IDLE
- out_valid  out  1  one-cycle pulse: out_value/out_rank/out_flow valid
- out_value  out  32  dequeued value
- out_rank  out  32  dequeued rank
- out_flow  out  FLOW_W  flow the entry came from
- out_empty  out  1  one-cycle pulse: deq_req found all flows empty
- flow_empty  out  FLOWS  bit f = (cnt[f] == 0)
- st_push  out  1  store push, combinational = in_push & in_ready
- st_push_rank  out  32  = in_rank
- st_push_value  out  32  = in_value
- st_push_flow  out  FLOWS  one-hot of in_flow when st_push, else 0
- st_pop  out  1  store pop, registered
- st_pop_flow  out  FLOWS  one-hot granted flow, registered; 0 when st_pop=0
- st_pop_value  in  32  store pop_value
- st_pop_rank  in  32  store pop_rank
- st_pop_valid  in  1  store pop_valid

Behaviour:
- Reset (async) clears:
  - all cnt[f] to 0, so flow_empty is all ones
  - state to IDLE
  - out_valid, out_empty, st_pop, st_pop_flow, out_value, out_rank, out_flow to 0
  - rr_ptr to FLOWS-1, so the first search starts at flow 0
- Occupancy: cnt[f] is $clog2(SIZE+1) bits.
  - Accepted push: +1.
  - ISSUE grant: -1.
  - Push and grant on the same flow in the same cycle: unchanged.
  - A push with in_ready=0 is dropped; no store access, no count change.
- Grant eligibility uses cnt values registered before the current cycle. A same-cycle push never makes an empty flow eligible (store bypass is not relied on).
- FSM:
  - IDLE, deq_req=1:
    - If any cnt > 0: pick the first non-empty flow searching rr_ptr+1, rr_ptr+2, ... modulo FLOWS; set rr_ptr to it; go to ISSUE.
    - If all flows are empty: pulse out_empty the next cycle and stay in IDLE.
  - ISSUE (1 cycle): st_pop=1, st_pop_flow=one-hot(grant), decrement cnt; go to WAIT.
  - WAIT: when st_pop_valid=1, register st_pop_value/st_pop_rank and out_flow=grant, pulse out_valid the next cycle, and return to IDLE.
- Latency: deq_req high in cycle t (IDLE) -> st_pop in t+1 -> st_pop_valid in t+2 -> out_valid in t+3. Maximum dequeue throughput is one per 3 cycles.
- st_pop_valid outside WAIT is ignored.
- Pushes are accepted in every state, independent of the FSM.
- Flow index wrap: grant search wraps from FLOWS-1 to 0; in_flow >= FLOWS gives in_ready=0.
- Reset mid-dequeue (ISSUE/WAIT): the transaction is abandoned, no out_valid, and any late st_pop_valid is ignored.

Optional Feature:
- STRICT_PRIO_EN
- Defined: grant is the lowest-index non-empty flow (flow 0 highest priority); rr_ptr is unused and held at reset value.
- Undefined: round-robin as above.

Test Plan:
- Reset, then deq_req=1 with no pushes -> out_empty pulses at t+1, st_pop never asserted, flow_empty=10'h3FF.
- Push (rank 5, value 0xA, flow 3) then deq_req -> st_pop_flow=10'h008 at t+1; out_valid at t+3 with out_value=0xA, out_rank=5, out_flow=3; flow_empty[3]=1.
- Push one entry each to flows 1, 4, 7, then 3 deqs -> out_flow order 1, 4, 7. With STRICT_PRIO_EN and pushes to 7, 4, 1, order is 1, 4, 7.
- Push SIZE=50 entries to flow 2 -> in_ready=0 for flow 2; 51st push is not forwarded (st_push=0) and cnt stays 50; in_flow=12 gives in_ready=0.
- Push to flow 0 in the same cycle as its ISSUE grant with cnt[0]=1 -> cnt[0] stays 1; next deq returns the new entry.
- Assert rst during WAIT -> out_valid never pulses, state is IDLE, all counts are 0, and a subsequent deq_req gives out_empty.
